// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: multi-precision sequencer around a 4-bit combinational ALU.
// Takes one wide operation over a valid/ready command port. Drives the ALU
// one nibble per cycle, LSB nibble first, with optional carry chaining.
// Returns the assembled result and flags over a valid/ready result port.
// Optional feature macro: ALU_SEQ_FLAGS_EN builds the res_eq/res_zero flags.
// When it is undefined, both flags are tied to 0.
module alu_nibble_seq #(
    parameter int unsigned NIB = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [4*NIB-1:0]   cmd_a,
    input  logic [4*NIB-1:0]   cmd_b,
    input  logic [3:0]         cmd_sel,
    input  logic               cmd_m,
    input  logic               cmd_cin,
    input  logic               cmd_chain,
    output logic [3:0]         alu_in1,
    output logic [3:0]         alu_in2,
    output logic [3:0]         alu_sel,
    output logic               alu_m,
    output logic               alu_cin,
    input  logic [3:0]         alu_out,
    input  logic               alu_cout,
    input  logic               alu_comp,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [4*NIB-1:0]   res_data,
    output logic               res_cout,
    output logic               res_eq,
    output logic               res_zero
);

    localparam int unsigned W  = 4 * NIB;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   data_q, data_d;
    logic [3:0]     sel_q, sel_d;
    logic           m_q, m_d;
    logic           cin_q, cin_d;
    logic           chain_q, chain_d;
    logic           carry_q, carry_d;
    logic           cout_q, cout_d;
    logic [3:0]     nib_a, nib_b;

`ifdef ALU_SEQ_FLAGS_EN
    logic           eq_q, eq_d;
`else
    logic           unused_comp;
    assign unused_comp = alu_comp;
`endif

    // State and datapath registers; async reset returns everything to idle values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            m_q     <= 1'b0;
            cin_q   <= 1'b0;
            chain_q <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            m_q     <= m_d;
            cin_q   <= cin_d;
            chain_q <= chain_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    // Running AND of per-nibble equality.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eq_q <= 1'b0;
        end else begin
            eq_q <= eq_d;
        end
    end
`endif

    // Next-state, ALU drive and handshake outputs.
    // EXEC spends cnt=0 as a turnaround cycle after accept (ALU drive idle).
    // Counts 1..NIB present nibble cnt-1, giving the NIB+1 edge latency.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        data_d    = data_q;
        sel_d     = sel_q;
        m_d       = m_q;
        cin_d     = cin_q;
        chain_d   = chain_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
`ifdef ALU_SEQ_FLAGS_EN
        eq_d      = eq_q;
`endif
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        alu_in1   = '0;
        alu_in2   = '0;
        alu_sel   = '0;
        alu_m     = 1'b0;
        alu_cin   = 1'b0;
        nib_a     = '0;
        nib_b     = '0;

        for (int unsigned i = 0; i < NIB; i++) begin
            if (cnt_q == CW'(i + 1)) begin
                nib_a = a_q[4*i +: 4];
                nib_b = b_q[4*i +: 4];
            end
        end

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    sel_d   = cmd_sel;
                    m_d     = cmd_m;
                    cin_d   = cmd_cin;
                    chain_d = cmd_chain;
                    cnt_d   = '0;
                    data_d  = '0;
                    carry_d = 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
                    eq_d    = 1'b1;
`endif
                    state_d = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q != '0) begin
                    alu_in1 = nib_a;
                    alu_in2 = nib_b;
                    alu_sel = sel_q;
                    alu_m   = m_q;
                    alu_cin = (cnt_q == CW'(1) || !chain_q) ? cin_q : carry_q;
                    for (int unsigned i = 0; i < NIB; i++) begin
                        if (cnt_q == CW'(i + 1)) begin
                            data_d[4*i +: 4] = alu_out;
                        end
                    end
                    carry_d = alu_cout;
`ifdef ALU_SEQ_FLAGS_EN
                    eq_d    = eq_q & alu_comp;
`endif
                    if (cnt_q == CW'(NIB)) begin
                        cout_d  = alu_cout;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign res_data = data_q;
    assign res_cout = cout_q;

`ifdef ALU_SEQ_FLAGS_EN
    assign res_eq   = eq_q;
    assign res_zero = (data_q == '0);
`else
    assign res_eq   = 1'b0;
    assign res_zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Self-checking bench for alu_nibble_seq (NIB=4) with a behavioural ALU stub.
// Expected flags follow ALU_SEQ_FLAGS_EN if it is defined for the build.
module tb_alu_nibble_seq;

    localparam int unsigned NIB = 4;
    localparam int unsigned W   = 4 * NIB;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [W-1:0]   cmd_a = '0;
    logic [W-1:0]   cmd_b = '0;
    logic [3:0]     cmd_sel = '0;
    logic           cmd_m = 1'b0;
    logic           cmd_cin = 1'b0;
    logic           cmd_chain = 1'b0;
    logic [3:0]     alu_in1, alu_in2, alu_sel;
    logic           alu_m, alu_cin;
    logic [3:0]     alu_out;
    logic           alu_cout, alu_comp;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [W-1:0]   res_data;
    logic           res_cout, res_eq, res_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign alu_out  = alu_in1 ^ alu_in2 ^ {3'b000, alu_cin};
    assign alu_cout = alu_in1[3];
    assign alu_comp = (alu_in1 == alu_in2);

    alu_nibble_seq #(.NIB(NIB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_sel   (cmd_sel),
        .cmd_m     (cmd_m),
        .cmd_cin   (cmd_cin),
        .cmd_chain (cmd_chain),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_sel   (alu_sel),
        .alu_m     (alu_m),
        .alu_cin   (alu_cin),
        .alu_out   (alu_out),
        .alu_cout  (alu_cout),
        .alu_comp  (alu_comp),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_cout  (res_cout),
        .res_eq    (res_eq),
        .res_zero  (res_zero)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: nibble-serial evaluation of the stub ALU with plain arithmetic.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic chain,
                                  output logic [W-1:0] d, output logic co,
                                  output logic eq, output logic zero);
        logic       c;
        logic [3:0] an, bn;
        c  = cin;
        d  = '0;
        eq = 1'b1;
        for (int i = 0; i < int'(NIB); i++) begin
            an = a[4*i +: 4];
            bn = b[4*i +: 4];
            if (!chain) c = cin;
            d[4*i +: 4] = an ^ bn ^ {3'b000, c};
            c  = an[3];
            eq = eq & (an == bn);
        end
        co   = c;
        zero = (d == '0);
`ifndef ALU_SEQ_FLAGS_EN
        eq   = 1'b0;
        zero = 1'b0;
`endif
    endfunction

    // Present a command and return #1 after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] sel,
                        input logic m, input logic cin, input logic chain);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_m = m; cmd_cin = cin; cmd_chain = chain;
        while (!cmd_ready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_a = W'($urandom); cmd_b = W'($urandom); cmd_sel = 4'($urandom);
        cmd_m = 1'($urandom); cmd_cin = 1'($urandom); cmd_chain = 1'($urandom);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input logic chain);
        logic [W-1:0] ed;
        logic         eco, eeq, ez;
        model(a, b, cin, chain, ed, eco, eeq, ez);
        chk({tag, "_valid"}, {63'd0, res_valid}, 64'd1);
        chk({tag, "_data"},  64'(res_data), 64'(ed));
        chk({tag, "_cout"},  {63'd0, res_cout}, {63'd0, eco});
        chk({tag, "_eq"},    {63'd0, res_eq}, {63'd0, eeq});
        chk({tag, "_zero"},  {63'd0, res_zero}, {63'd0, ez});
    endtask

    task automatic take_result(input int delay);
        repeat (delay) begin
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("ready_after_hs", {62'd0, cmd_ready, res_valid}, 64'd2);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic chain, input int delay);
        int lat;
        send(a, b, 4'($urandom), 1'($urandom), cin, chain);
        wait_result(lat);
        chk({tag, "_latency"}, 64'(lat), 64'(NIB + 1));
        check_result(tag, a, b, cin, chain);
        take_result(delay);
    endtask

    initial begin
        int           lat;
        logic [W-1:0] hold;
        logic [W-1:0] ra, rb;

        // Reset state
        #1;
        chk("rst_ready_valid", {62'd0, cmd_ready, res_valid}, 64'd2);
        chk("rst_alu", {50'd0, alu_in1, alu_in2, alu_sel, alu_m, alu_cin}, 64'd0);
        chk("rst_data", 64'(res_data), 64'd0);
        chk("rst_cout_eq", {62'd0, res_cout, res_eq}, 64'd0);
`ifdef ALU_SEQ_FLAGS_EN
        chk("rst_zero", {63'd0, res_zero}, 64'd1);
`else
        chk("rst_zero", {63'd0, res_zero}, 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Chained carry example
        run_op("chain", 16'h8F81, 16'h0F01, 1'b1, 1'b1, 0);

        // Unchained, equal operands: zero result
        run_op("equal", 16'h1234, 16'h1234, 1'b0, 1'b0, 1);

        // Per-nibble drive
        send(16'hABCD, 16'h0000, 4'hA, 1'b1, 1'b0, 1'b0);
        chk("turn_alu", {50'd0, alu_in1, alu_in2, alu_sel, alu_m, alu_cin}, 64'd0);
        hold = 16'hABCD;
        for (int i = 0; i < int'(NIB); i++) begin
            @(posedge clk); #1;
            chk("nib_in1", 64'(alu_in1), 64'(hold[4*i +: 4]));
            chk("nib_ctl", {55'd0, alu_in2, alu_sel, alu_m}, {55'd0, 4'h0, 4'hA, 1'b1});
        end
        @(posedge clk); #1;
        chk("done_alu", {50'd0, alu_in1, alu_in2, alu_sel, alu_m, alu_cin}, 64'd0);
        check_result("drive", 16'hABCD, 16'h0000, 1'b0, 1'b0);

        // Backpressure on the ABCD result
        hold = res_data;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                cmd_valid = 1'b1; cmd_a = 16'h5555; cmd_b = 16'h0F0F;
            end
            if (i == 4) cmd_valid = 1'b0;
            chk("bp_state", {62'd0, res_valid, cmd_ready}, 64'd2);
            chk("bp_data", 64'(res_data), 64'(hold));
            @(posedge clk); #1;
        end
        take_result(0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_ignored", {62'd0, cmd_ready, res_valid}, 64'd2);
            chk("bp_hold", 64'(res_data), 64'(hold));
        end

        // Reset during EXEC, after nibble 1
        send(16'hFFFF, 16'h1357, 4'h5, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_nib1", 64'(alu_in1), 64'hF);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_state", {62'd0, res_valid, cmd_ready}, 64'd1);
        chk("midrst_alu", {50'd0, alu_in1, alu_in2, alu_sel, alu_m, alu_cin}, 64'd0);
        chk("midrst_data", 64'(res_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst", 16'hC3A5, 16'h5A3C, 1'b1, 1'b1, 0);

        // Back-to-back commands presented continuously
        cmd_valid = 1'b1;
        cmd_a = 16'h7E11; cmd_b = 16'h0F22; cmd_sel = 4'h3; cmd_m = 1'b0;
        cmd_cin = 1'b1; cmd_chain = 1'b1;
        @(posedge clk); #1;
        cmd_a = 16'h4444; cmd_b = 16'h4444; cmd_cin = 1'b0; cmd_chain = 1'b0;
        res_ready = 1'b1;
        wait_result(lat);
        chk("b2b1_latency", 64'(lat), 64'(NIB + 1));
        check_result("b2b1", 16'h7E11, 16'h0F22, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("b2b_gap", {62'd0, cmd_ready, res_valid}, 64'd2);
        @(posedge clk); #1;
        chk("b2b_accept", {63'd0, cmd_ready}, 64'd0);
        cmd_valid = 1'b0;
        wait_result(lat);
        chk("b2b2_latency", 64'(lat), 64'(NIB + 1));
        check_result("b2b2", 16'h4444, 16'h4444, 1'b0, 1'b0);
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("b2b2_released", {62'd0, cmd_ready, res_valid}, 64'd2);

        // Randomized operations against the model
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = (i % 5 == 0) ? ra : W'($urandom);
            run_op("rand", ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
